regfile_unit: RTL



---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_scoreboard.sv | 62 ++++++
 rtl/regfile_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types, constants and the address decoder for the register file block.
package regfile_pkg;

  localparam logic [31:0] RESET_PC_DFLT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP       = 32'd4;

  localparam int DW_DFLT   = 32;
  localparam int NREG_DFLT = 32;
  localparam int AW_DFLT   = $clog2(NREG_DFLT);

  typedef logic [AW_DFLT-1:0] reg_addr_t;
  typedef logic [DW_DFLT-1:0] reg_data_t;

  // One-hot decode of an address, evaluated at register position idx.
  // Addresses that match no position (>= NREG) decode to all-zero.
  function automatic logic onehot_decode(input logic [31:0] addr, input int idx);
    return addr == 32'(idx);
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set at reserve,
// cleared at writeback, with reserve taking priority over a same-cycle clear.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NREG     = 32,
  parameter int NREAD    = 2,
  parameter int NWRITE   = 2,
  parameter int ZERO_REG = 1,
  parameter int AW       = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NWRITE-1:0]    wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  input  logic                rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic [NREAD*AW-1:0]  rd_addr,
  output logic [NREAD-1:0]     rd_busy
);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [NREG-1:0]  set_vec, clr_vec;
  logic [NREAD-1:0] rd_busy_q, rd_busy_d;

  // Next busy vector and the busy flags that go with this cycle's reads
  always_comb begin
    clr_vec   = '0;
    set_vec   = '0;
    rd_busy_d = '0;
    for (int w = 0; w < NWRITE; w++) begin
      for (int r = 0; r < NREG; r++) begin
        if (wr_en[w] && onehot_decode(32'(wr_addr[w*AW +: AW]), r)) clr_vec[r] = 1'b1;
      end
    end
    for (int r = 0; r < NREG; r++) begin
      if (rsv_en && onehot_decode(32'(rsv_addr), r) && !(ZERO_REG != 0 && r == 0))
        set_vec[r] = 1'b1;
    end
    // A new reservation supersedes the retiring write to the same register.
    busy_d = (busy_q & ~clr_vec) | set_vec;
    for (int i = 0; i < NREAD; i++) begin
      for (int r = 0; r < NREG; r++) begin
        if (onehot_decode(32'(rd_addr[i*AW +: AW]), r)) rd_busy_d[i] = busy_d[r];
      end
    end
  end

  // Busy state and registered read-side flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q    <= '0;
      rd_busy_q <= '0;
    end else begin
      busy_q    <= busy_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign rd_busy = rd_busy_q;

endmodule

// File: rtl/regfile_unit.sv
// Architectural state block: program counter plus one register bank with
// registered, write-first read ports and a pending-write scoreboard.
module regfile_unit
  import regfile_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int          NREG     = 32,
  parameter int          NREAD    = 2,
  parameter int          NWRITE   = 2,
  parameter int          ZERO_REG = 1,
  parameter int          HAS_PC   = 1,
  parameter logic [31:0] RESET_PC = RESET_PC_DFLT,
  localparam int         AW       = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 pc_redirect,
  input  logic [31:0]          pc_target,
  input  logic                 pc_advance,
  output logic [31:0]          pc,
  input  logic [NREAD*AW-1:0]  rd_addr,
  output logic [NREAD*DW-1:0]  rd_data,
  output logic [NREAD-1:0]     rd_busy,
  input  logic [NWRITE-1:0]    wr_en,
  input  logic [NWRITE*AW-1:0] wr_addr,
  input  logic [NWRITE*DW-1:0] wr_data,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr
);

  logic [DW-1:0]       regs_q [NREG];
  logic [DW-1:0]       regs_d [NREG];
  logic [NREAD*DW-1:0] rd_data_q, rd_data_d;

  // Apply this cycle's writes; later ports overwrite earlier ones on conflict
  always_comb begin
    regs_d = regs_q;
    for (int w = 0; w < NWRITE; w++) begin
      if (wr_en[w]) begin
        for (int r = 0; r < NREG; r++) begin
          if (onehot_decode(32'(wr_addr[w*AW +: AW]), r) && !(ZERO_REG != 0 && r == 0))
            regs_d[r] = wr_data[w*DW +: DW];
        end
      end
    end
  end

  // Read from the post-write view so same-cycle writes bypass to the reader
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NREAD; i++) begin
      for (int r = 0; r < NREG; r++) begin
        if (onehot_decode(32'(rd_addr[i*AW +: AW]), r)) rd_data_d[i*DW +: DW] = regs_d[r];
      end
    end
  end

  // Register storage and registered read data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
      rd_data_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= regs_d[r];
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

  generate
    if (HAS_PC != 0) begin : g_pc
      logic [31:0] pc_q, pc_d;

      // Redirect beats sequential advance; otherwise hold
      always_comb begin
        pc_d = pc_q;
        if (pc_redirect)     pc_d = pc_target;
        else if (pc_advance) pc_d = pc_q + PC_STEP;
      end

      // Program counter register
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) pc_q <= RESET_PC;
        else       pc_q <= pc_d;
      end

      assign pc = pc_q;
    end else begin : g_no_pc
      assign pc = RESET_PC;
    end
  endgenerate

  regfile_scoreboard #(
    .NREG     (NREG),
    .NREAD    (NREAD),
    .NWRITE   (NWRITE),
    .ZERO_REG (ZERO_REG),
    .AW       (AW)
  ) u_scoreboard (
    .clk      (clk),
    .rstn     (rstn),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule
